act_row_dispatch: RTL and testbench
===================================

ACT_ROW_DISPATCH -- requirements
Module: act_row_dispatch

Interface
REQ-001 SHALL have parameter N_ROW, default 20, number of superblock rows fed.
REQ-002 SHALL have parameter WID_ACT, default 16, activation element width; one word is 2*WID_ACT bits.
REQ-003 SHALL have parameter WID_LEN, default 8, burst length field width.
REQ-004 SHALL have parameter WID_ROW, default $clog2(N_ROW), row index width.
REQ-005 SHALL have port clk_l, input, 1, sole clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports cmd_row (input, WID_ROW), cmd_len (input, WID_LEN), cmd_bcast (input, 1): burst target row, word count, broadcast flag.
REQ-008 SHALL have ports cmd_vld (input, 1) and cmd_rdy (output, 1): command handshake.
REQ-009 SHALL have ports in_data (input, 2*WID_ACT), in_vld (input, 1), in_rdy (output, 1): activation word stream.
REQ-010 SHALL have ports act_data_in (output, 2*WID_ACT*N_ROW), act_data_in_vld (output, N_ROW), act_data_in_req (input, N_ROW): per-row feed, row r at slice [r*2*WID_ACT +: 2*WID_ACT].
REQ-011 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), err (output, 1, one-cycle pulse).

Function
REQ-012 SHALL implement FSM states IDLE and STREAM; cmd_rdy = 1 only in IDLE.
REQ-013 Command accepted on cmd_vld & cmd_rdy; latches row, len, bcast into registers; if cmd_len != 0 and cmd_row < N_ROW (or bcast set), IDLE -> STREAM next cycle.
REQ-014 cmd_len = 0 SHALL be a no-op: stay IDLE, pulse done next cycle.
REQ-015 cmd_row >= N_ROW with bcast = 0 SHALL be rejected: stay IDLE, pulse err next cycle, no data consumed.
REQ-016 Each row SHALL hold a one-entry output register; act_data_in_vld[r] set when loaded, cleared when act_data_in_req[r] & act_data_in_vld[r] and no reload same cycle.
REQ-017 Unicast: in_rdy = STREAM & (~vld[row] | req[row]); word accepted on in_vld & in_rdy loads row register, visible at output next cycle (latency 1).
REQ-018 Broadcast: in_rdy = STREAM & all rows (~vld[r] | req[r]); accepted word loads every row register simultaneously.
REQ-019 Simultaneous drain and load on one row SHALL keep vld = 1 with new data; no bubble, no loss, no duplicate.
REQ-020 Remaining-word counter loaded with cmd_len, decremented per accepted word; on acceptance at count 1, STREAM -> IDLE and done pulses next cycle.
REQ-021 Row registers not targeted SHALL hold data and vld unchanged; pending words drain after return to IDLE, and a new command may be accepted while they drain.
REQ-022 busy = STREAM | any act_data_in_vld bit set.
REQ-023 in_data SHALL NOT be consumed in IDLE (in_rdy = 0).

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, counter 0, all act_data_in_vld 0, act_data_in 0, done 0, err 0, busy 0; cmd_rdy = 1 and in_rdy = 0 after release.
REQ-025 Reset mid-burst SHALL discard the burst and all buffered words; no partial done.

Configuration
REQ-026 Macro ACT_ROW_DISPATCH_BCAST_EN defined: broadcast per REQ-018.
REQ-027 Macro undefined: cmd_bcast ignored (treated 0), broadcast logic absent; cmd_row >= N_ROW always errs.

Verification
REQ-028 cmd row 3 len 4, in_vld held, req[3] = 1 -> 4 words on row 3 at consecutive cycles, first one cycle after acceptance, done pulses once, other rows vld = 0.
REQ-029 Row 5 len 3 with req[5] low 2 cycles mid-burst -> in_rdy low those cycles, words in order, none lost or repeated.
REQ-030 cmd_row = 20 (N_ROW = 20), bcast 0 -> err pulse, cmd_rdy stays 1, in_rdy stays 0.
REQ-031 With BCAST_EN, bcast len 2, req[7] = 0 others 1 -> stall until req[7] = 1; each word on all 20 rows exactly once.
REQ-032 cmd_len = 0 -> done pulse next cycle, no in_rdy assertion.
REQ-033 rst_n low after 2 of 6 words -> all outputs zero immediately; after release, new len 1 command completes normally.

Source files
------------

// File: rtl/act_row_dispatch.sv
// Burst dispatcher: routes an activation word stream into per-row one-entry output registers.
// Optional broadcast to every row is enabled by defining ACT_ROW_DISPATCH_BCAST_EN.
module act_row_dispatch #(
    parameter int N_ROW   = 20,
    parameter int WID_ACT = 16,
    parameter int WID_LEN = 8,
    parameter int WID_ROW = $clog2(N_ROW)
) (
    input  logic                         clk_l,
    input  logic                         rst_n,
    input  logic [WID_ROW-1:0]           cmd_row,
    input  logic [WID_LEN-1:0]           cmd_len,
    input  logic                         cmd_bcast,
    input  logic                         cmd_vld,
    output logic                         cmd_rdy,
    input  logic [2*WID_ACT-1:0]         in_data,
    input  logic                         in_vld,
    output logic                         in_rdy,
    output logic [2*WID_ACT*N_ROW-1:0]   act_data_in,
    output logic [N_ROW-1:0]             act_data_in_vld,
    input  logic [N_ROW-1:0]             act_data_in_req,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int WID_W = 2*WID_ACT;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;
    localparam logic [WID_ROW:0] N_ROW_C = (WID_ROW+1)'(N_ROW);

    logic [0:0]         state_q, state_d;
    logic [WID_ROW-1:0] row_q, row_d;
    logic [WID_LEN-1:0] cnt_q, cnt_d;
    logic               bcast_q, bcast_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [N_ROW-1:0]   vld_q, vld_d;
    logic [WID_W-1:0]   data_q [N_ROW];
    logic [WID_W-1:0]   data_d [N_ROW];

    logic               cmd_bcast_eff;
    logic               cmd_ok;
    logic               cmd_acc;
    logic               in_acc;
    logic [N_ROW-1:0]   tgt;

`ifdef ACT_ROW_DISPATCH_BCAST_EN
    assign cmd_bcast_eff = cmd_bcast;
`else
    assign cmd_bcast_eff = cmd_bcast & 1'b0;
`endif

    assign cmd_rdy = (state_q == ST_IDLE);
    assign cmd_acc = cmd_vld & cmd_rdy;
    assign cmd_ok  = ({1'b0, cmd_row} < N_ROW_C) | cmd_bcast_eff;

    // A row blocks the stream only if it is targeted, full, and not being drained this cycle.
    always_comb begin
        for (int unsigned r = 0; r < N_ROW; r++) begin
            tgt[r] = bcast_q | (row_q == WID_ROW'(r));
        end
    end

    assign in_rdy = (state_q == ST_STREAM) & (&(~tgt | ~vld_q | act_data_in_req));
    assign in_acc = in_vld & in_rdy;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        bcast_d = bcast_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        vld_d   = vld_q;
        data_d  = data_q;
        if (state_q == ST_IDLE) begin
            if (cmd_acc) begin
                row_d   = cmd_row;
                cnt_d   = cmd_len;
                bcast_d = cmd_bcast_eff;
                if (cmd_len == '0) begin
                    done_d = 1'b1;
                end else if (!cmd_ok) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_STREAM;
                end
            end
        end else if (in_acc) begin
            cnt_d = cnt_q - WID_LEN'(1);
            if (cnt_q == WID_LEN'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
        for (int unsigned r = 0; r < N_ROW; r++) begin
            if (in_acc && tgt[r]) begin
                data_d[r] = in_data;
                vld_d[r]  = 1'b1;
            end else if (act_data_in_req[r]) begin
                vld_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            bcast_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= '0;
            for (int unsigned r = 0; r < N_ROW; r++) begin
                data_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            bcast_q <= bcast_d;
            done_q  <= done_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        act_data_in = '0;
        for (int unsigned r = 0; r < N_ROW; r++) begin
            act_data_in[r*WID_W +: WID_W] = data_q[r];
        end
    end

    assign act_data_in_vld = vld_q;
    assign busy            = (state_q == ST_STREAM) | (|vld_q);
    assign done            = done_q;
    assign err             = err_q;

endmodule

// File: tb/tb_act_row_dispatch.sv
// Directed self-checking bench for act_row_dispatch (default N_ROW=20, WID_ACT=16).
module tb_act_row_dispatch;

    localparam int N_ROW   = 20;
    localparam int WID_ACT = 16;
    localparam int WID_LEN = 8;
    localparam int WID_ROW = 5;
    localparam int WW      = 2*WID_ACT;
    localparam int DW      = WW*N_ROW;
    localparam logic [N_ROW-1:0] ONE = 1;

    logic                clk_l = 1'b0;
    logic                rst_n = 1'b0;
    logic [WID_ROW-1:0]  cmd_row = '0;
    logic [WID_LEN-1:0]  cmd_len = '0;
    logic                cmd_bcast = 1'b0;
    logic                cmd_vld = 1'b0;
    logic                cmd_rdy;
    logic [WW-1:0]       in_data = '0;
    logic                in_vld = 1'b0;
    logic                in_rdy;
    logic [DW-1:0]       act_data_in;
    logic [N_ROW-1:0]    act_data_in_vld;
    logic [N_ROW-1:0]    act_data_in_req = '0;
    logic                busy, done, err;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_data = '0;

    act_row_dispatch #(
        .N_ROW(N_ROW), .WID_ACT(WID_ACT), .WID_LEN(WID_LEN), .WID_ROW(WID_ROW)
    ) dut (
        .clk_l(clk_l), .rst_n(rst_n),
        .cmd_row(cmd_row), .cmd_len(cmd_len), .cmd_bcast(cmd_bcast),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .act_data_in(act_data_in), .act_data_in_vld(act_data_in_vld),
        .act_data_in_req(act_data_in_req),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk_l = ~clk_l;

    task automatic tick();
        @(posedge clk_l);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int r, input logic [WW-1:0] w);
        exp_data[r*WW +: WW] = w;
    endtask

    task automatic put_all(input logic [WW-1:0] w);
        for (int r = 0; r < N_ROW; r++) exp_data[r*WW +: WW] = w;
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_vld", act_data_in_vld, '0);
        chk("rst_data", act_data_in, '0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_cmd_rdy", cmd_rdy, 1);
        chk("rel_in_rdy", in_rdy, 0);

        // row 3, len 4, stream held valid
        cmd_row = 5'd3; cmd_len = 8'd4; cmd_vld = 1'b1;
        act_data_in_req = ONE << 3;
        in_vld = 1'b1; in_data = 32'hA000_0000;
        tick();
        cmd_vld = 1'b0;
        chk("u_cmd_rdy_low", cmd_rdy, 0);
        chk("u_in_rdy", in_rdy, 1);
        chk("u_vld_before", act_data_in_vld, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            put(3, 32'hA000_0000 + 32'(i));
            in_data = 32'hA000_0001 + 32'(i);
            chk("u_vld", act_data_in_vld, ONE << 3);
            chk("u_data", act_data_in, exp_data);
            chk("u_done", done, (i == 3) ? 1 : 0);
        end
        chk("u_cmd_rdy_back", cmd_rdy, 1);
        in_vld = 1'b0;
        tick();
        chk("u_done_once", done, 0);
        chk("u_drained", act_data_in_vld, '0);
        chk("u_idle_busy", busy, 0);

        // row 5, len 3, consumer stalls 2 cycles
        cmd_row = 5'd5; cmd_len = 8'd3; cmd_vld = 1'b1;
        act_data_in_req = ONE << 5;
        in_vld = 1'b1; in_data = 32'hB000_0000;
        tick();
        cmd_vld = 1'b0;
        tick();
        put(5, 32'hB000_0000);
        chk("s_w0", act_data_in, exp_data);
        chk("s_w0_vld", act_data_in_vld, ONE << 5);
        act_data_in_req = '0;
        in_data = 32'hB000_0001;
        #1;
        chk("s_rdy_low0", in_rdy, 0);
        tick();
        chk("s_hold0", act_data_in, exp_data);
        chk("s_rdy_low1", in_rdy, 0);
        tick();
        chk("s_hold1", act_data_in, exp_data);
        chk("s_hold1_vld", act_data_in_vld, ONE << 5);
        act_data_in_req = ONE << 5;
        #1;
        chk("s_rdy_back", in_rdy, 1);
        tick();
        put(5, 32'hB000_0001);
        chk("s_w1", act_data_in, exp_data);
        chk("s_w1_vld", act_data_in_vld, ONE << 5);
        chk("s_w1_done", done, 0);
        in_data = 32'hB000_0002;
        tick();
        put(5, 32'hB000_0002);
        chk("s_w2", act_data_in, exp_data);
        chk("s_w2_done", done, 1);
        in_vld = 1'b0;
        tick();
        chk("s_drained", act_data_in_vld, '0);

        // out-of-range row without broadcast
        cmd_row = 5'd20; cmd_len = 8'd2; cmd_bcast = 1'b0; cmd_vld = 1'b1;
        in_vld = 1'b1; in_data = 32'hC000_0000;
        tick();
        cmd_vld = 1'b0;
        chk("e_err", err, 1);
        chk("e_cmd_rdy", cmd_rdy, 1);
        chk("e_in_rdy", in_rdy, 0);
        tick();
        chk("e_err_pulse", err, 0);
        chk("e_in_rdy2", in_rdy, 0);
        chk("e_no_data", act_data_in_vld, '0);
        in_vld = 1'b0;

        // zero-length command
        cmd_row = 5'd2; cmd_len = 8'd0; cmd_vld = 1'b1;
        tick();
        cmd_vld = 1'b0;
        chk("z_done", done, 1);
        chk("z_in_rdy", in_rdy, 0);
        chk("z_cmd_rdy", cmd_rdy, 1);
        tick();
        chk("z_done_pulse", done, 0);

`ifdef ACT_ROW_DISPATCH_BCAST_EN
        // broadcast len 2 with row 7 stalling
        cmd_row = 5'd0; cmd_len = 8'd2; cmd_bcast = 1'b1; cmd_vld = 1'b1;
        act_data_in_req = ~(ONE << 7);
        in_vld = 1'b1; in_data = 32'hD000_0000;
        tick();
        cmd_vld = 1'b0; cmd_bcast = 1'b0;
        chk("b_rdy0", in_rdy, 1);
        tick();
        put_all(32'hD000_0000);
        chk("b_w0_vld", act_data_in_vld, '1);
        chk("b_w0_data", act_data_in, exp_data);
        chk("b_stall", in_rdy, 0);
        in_data = 32'hD000_0001;
        tick();
        chk("b_only7", act_data_in_vld, ONE << 7);
        chk("b_stall2", in_rdy, 0);
        tick();
        chk("b_only7b", act_data_in_vld, ONE << 7);
        act_data_in_req = '1;
        tick();
        put_all(32'hD000_0001);
        chk("b_w1_vld", act_data_in_vld, '1);
        chk("b_w1_data", act_data_in, exp_data);
        chk("b_done", done, 1);
        in_vld = 1'b0;
        tick();
        chk("b_drained", act_data_in_vld, '0);
`else
        // without broadcast support the flag is ignored
        cmd_row = 5'd20; cmd_len = 8'd2; cmd_bcast = 1'b1; cmd_vld = 1'b1;
        tick();
        cmd_vld = 1'b0; cmd_bcast = 1'b0;
        chk("nb_err", err, 1);
        chk("nb_in_rdy", in_rdy, 0);
        tick();
`endif

        // reset in the middle of a 6-word burst
        cmd_row = 5'd1; cmd_len = 8'd6; cmd_vld = 1'b1;
        act_data_in_req = ONE << 1;
        in_vld = 1'b1; in_data = 32'hE000_0000;
        tick();
        cmd_vld = 1'b0;
        tick();
        in_data = 32'hE000_0001;
        tick();
        put(1, 32'hE000_0001);
        chk("r_mid_data", act_data_in, exp_data);
        chk("r_mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        exp_data = '0;
        chk("r_vld0", act_data_in_vld, '0);
        chk("r_data0", act_data_in, '0);
        chk("r_busy0", busy, 0);
        chk("r_done0", done, 0);
        chk("r_in_rdy0", in_rdy, 0);
        tick();
        rst_n = 1'b1;
        in_vld = 1'b0;
        tick();
        chk("r_no_done", done, 0);
        chk("r_cmd_rdy", cmd_rdy, 1);
        chk("r_busy_idle", busy, 0);
        cmd_row = 5'd1; cmd_len = 8'd1; cmd_vld = 1'b1;
        in_vld = 1'b1; in_data = 32'hE000_0009;
        tick();
        cmd_vld = 1'b0;
        chk("r_new_rdy", in_rdy, 1);
        tick();
        put(1, 32'hE000_0009);
        chk("r_new_data", act_data_in, exp_data);
        chk("r_new_vld", act_data_in_vld, ONE << 1);
        chk("r_new_done", done, 1);
        in_vld = 1'b0;
        tick();
        chk("r_new_done_pulse", done, 0);
        chk("r_new_drained", act_data_in_vld, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
